// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring phase monitor.
package ring_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int RING_W  = 4;
   localparam int PHASE_W = $clog2(RING_W);

   // Rotates the low w bits of v left by one; supports rings up to 64 bits.
   function automatic logic [63:0] rotl1(
      input logic [63:0] v,
      input int          w
   );
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         r[(i + 1) % w] = v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_enc.sv
// One-hot detector and binary encoder for the ring code.
module onehot_enc #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]         code,
   output logic                     is_onehot,
   output logic [$clog2(WIDTH)-1:0] idx
);

   localparam int IW = $clog2(WIDTH);

   int n;

   always_comb begin
      n   = 0;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (code[i]) begin
            n   = n + 1;
            idx = IW'(i);
         end
      end
      is_onehot = (n == 1);
   end

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring counter phase monitor: lock, phase, revolutions, errors.
// Define RING_ERR_CNT_EN to add the saturating err_cnt output.
module ring_phase_monitor
   import ring_pkg::*;
#(
   parameter int WIDTH  = RING_W,
   parameter int LOCK_N = 3,
   parameter int REV_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         count,
   input  logic                     in_valid,
   input  logic                     clr_err,
   output logic [$clog2(WIDTH)-1:0] phase,
   output logic                     locked,
   output logic                     rev_tick,
   output logic [REV_W-1:0]         rev_cnt,
   output logic                     err,
   output logic                     err_sticky
`ifdef RING_ERR_CNT_EN
   ,
   output logic [7:0]               err_cnt
`endif
);

   localparam int PW = $clog2(WIDTH);
   localparam int GW = $clog2(LOCK_N + 1);

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic [GW-1:0]    good_cnt;

   logic             oh;
   logic [PW-1:0]    idx;
   logic [WIDTH-1:0] nxt;
   logic             good;
   logic             wrap;
   logic             err_hit;

   onehot_enc #(.WIDTH(WIDTH)) u_enc (
      .code      (count),
      .is_onehot (oh),
      .idx       (idx)
   );

   assign nxt     = WIDTH'(rotl1(64'(prev), WIDTH));
   assign good    = oh && (count == nxt);
   assign wrap    = prev[WIDTH-1] & count[0];
   assign err_hit = in_valid && (state == LOCKED) && !good;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SEARCH;
         prev       <= '0;
         good_cnt   <= '0;
         phase      <= '0;
         rev_cnt    <= '0;
         locked     <= 1'b0;
         rev_tick   <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         rev_tick <= 1'b0;
         err      <= 1'b0;
         // error beats a simultaneous clear
         if (err_hit) begin
            err_sticky <= 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
         end
         if (in_valid) begin
            unique case (state)
               SEARCH: begin
                  if (oh) begin
                     state    <= ACQUIRE;
                     prev     <= count;
                     good_cnt <= '0;
                  end
               end
               ACQUIRE: begin
                  if (!oh) begin
                     state <= SEARCH;
                  end else begin
                     prev  <= count;
                     phase <= idx;
                     if (!good) begin
                        good_cnt <= '0;
                     end else if (good_cnt == GW'(LOCK_N - 1)) begin
                        good_cnt <= good_cnt + 1'b1;
                        state    <= LOCKED;
                        locked   <= 1'b1;
                     end else begin
                        good_cnt <= good_cnt + 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (good) begin
                     prev  <= count;
                     phase <= idx;
                     if (wrap) begin
                        rev_tick <= 1'b1;
                        rev_cnt  <= rev_cnt + 1'b1;
                     end
                  end else begin
                     err    <= 1'b1;
                     locked <= 1'b0;
                     state  <= SEARCH;
                  end
               end
               default: begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef RING_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (err_hit) begin
         if (clr_err) begin
            err_cnt <= 8'd1;
         end else if (err_cnt != 8'hff) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end else if (clr_err) begin
         err_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor (WIDTH=4, LOCK_N=3).
module tb_ring_phase_monitor;

   typedef struct {
      logic       lk;
      int         ph;
      logic       tk;
      logic [7:0] rc;
      logic       er;
      logic       st;
      logic [7:0] ec;
      string      nm;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] count;
   logic       in_valid;
   logic       clr_err;
   logic [1:0] phase;
   logic       locked;
   logic       rev_tick;
   logic [7:0] rev_cnt;
   logic       err;
   logic       err_sticky;
`ifdef RING_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   logic [7:0] exp_ec = 8'd0;
   bit   done = 0;

   ring_phase_monitor #(
      .WIDTH  (4),
      .LOCK_N (3),
      .REV_W  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .count      (count),
      .in_valid   (in_valid),
      .clr_err    (clr_err),
      .phase      (phase),
      .locked     (locked),
      .rev_tick   (rev_tick),
      .rev_cnt    (rev_cnt),
      .err        (err),
      .err_sticky (err_sticky)
`ifdef RING_ERR_CNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(
      input logic       r,
      input logic       v,
      input logic [3:0] c,
      input logic       clr,
      input logic       lk,
      input int         ph,
      input logic       tk,
      input logic [7:0] rc,
      input logic       er,
      input logic       st,
      input string      nm
   );
      exp_t e;
      @(negedge clk);
      reset    = r;
      in_valid = v;
      count    = c;
      clr_err  = clr;
      e.lk = lk; e.ph = ph; e.tk = tk; e.rc = rc;
      e.er = er; e.st = st; e.ec = exp_ec; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: compares each cycle's outputs against the queued expectation.
   initial begin
      exp_t e;
      logic ok;
      logic [7:0] ec_got;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e  = q.pop_front();
            ok = 1'b1;
`ifdef RING_ERR_CNT_EN
            ec_got = err_cnt;
            if (ec_got !== e.ec) ok = 1'b0;
`else
            ec_got = e.ec;
`endif
            if (locked !== e.lk || rev_tick !== e.tk) ok = 1'b0;
            if (rev_cnt !== e.rc || err !== e.er) ok = 1'b0;
            if (err_sticky !== e.st) ok = 1'b0;
            if (e.ph >= 0 && phase !== 2'(e.ph)) ok = 1'b0;
            checks++;
            if (!ok) begin
               errors++;
               $display("FAIL %s: got lk=%b ph=%0d tk=%b rc=%0d er=%b st=%b ec=%0d exp lk=%b ph=%0d tk=%b rc=%0d er=%b st=%b ec=%0d",
                  e.nm, locked, phase, rev_tick, rev_cnt, err,
                  err_sticky, ec_got, e.lk, e.ph, e.tk, e.rc,
                  e.er, e.st, e.ec);
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      count    = 4'b0000;
      clr_err  = 1'b0;

      // 1: acquire and lock
      step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, "reset");
      step(0, 1, 4'b0001, 0, 0, -1, 0, 0, 0, 0, "acq0");
      step(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, "acq1");
      step(0, 1, 4'b0100, 0, 0, 2, 0, 0, 0, 0, "acq2");
      step(0, 1, 4'b1000, 0, 1, 3, 0, 0, 0, 0, "lock");

      // 2: revolutions and rev_cnt wrap
      step(0, 1, 4'b0001, 0, 1, 0, 1, 1, 0, 0, "rev1");
      for (int k = 1; k < 256; k++) begin
         step(0, 1, 4'b0010, 0, 1, 1, 0, 8'(k), 0, 0, "revp1");
         step(0, 1, 4'b0100, 0, 1, 2, 0, 8'(k), 0, 0, "revp2");
         step(0, 1, 4'b1000, 0, 1, 3, 0, 8'(k), 0, 0, "revp3");
         step(0, 1, 4'b0001, 0, 1, 0, 1, 8'(k + 1), 0, 0, "revwrap");
      end

      // 4: idle hold while locked
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 0, "idle");
      end
      step(0, 1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, "resume");

      // 3: error and relock
      exp_ec = 8'd1;
      step(0, 1, 4'b0011, 0, 0, 1, 0, 0, 1, 1, "err");
      step(0, 1, 4'b0010, 0, 0, -1, 0, 0, 0, 1, "re0");
      step(0, 1, 4'b0100, 0, 0, 2, 0, 0, 0, 1, "re1");
      step(0, 1, 4'b1000, 0, 0, 3, 0, 0, 0, 1, "re2");
      step(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0, 1, "relock");

      // 5: search rejects, acquire skip resets good count
      exp_ec = 8'd0;
      step(1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, "reset2");
      step(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, "srch0");
      step(0, 1, 4'b0101, 0, 0, 0, 0, 0, 0, 0, "srch2h");
      step(0, 1, 4'b0001, 0, 0, -1, 0, 0, 0, 0, "sk0");
      step(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, "sk1");
      step(0, 1, 4'b1000, 0, 0, 3, 0, 0, 0, 0, "skip");
      step(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, "sk2");
      step(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, "sk3");
      step(0, 1, 4'b0100, 0, 1, 2, 0, 0, 0, 0, "sklock");

      // 6: error beats clear, then clear, relock, reset mid-lock
      exp_ec = 8'd1;
      step(0, 1, 4'b0100, 1, 0, 2, 0, 0, 1, 1, "errclr");
      exp_ec = 8'd0;
      step(0, 0, 4'b0000, 1, 0, 2, 0, 0, 0, 0, "clr");
      step(0, 1, 4'b0001, 0, 0, -1, 0, 0, 0, 0, "r6a");
      step(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, "r6b");
      step(0, 1, 4'b0100, 0, 0, 2, 0, 0, 0, 0, "r6c");
      step(0, 1, 4'b1000, 0, 1, 3, 0, 0, 0, 0, "r6lock");
      step(1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, "rstlock");
      step(0, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, "postrst");

      step(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, "tail");
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, exp 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the one-hot ring counter output (count bus). Checks that the incoming code is one-hot and advances by exactly one position per valid sample. Once locked, reports the binary phase index, pulses on every full revolution and keeps a revolution count. Any bad sample while locked is flagged as an error and drops lock; the block then re-acquires automatically.

Parameters:
WIDTH, 4, ring length; width of count input (>=2)
LOCK_N, 3, consecutive correct steps needed to declare lock (>=1)
REV_W, 8, revolution counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
count  in  WIDTH  one-hot ring code from upstream ring counter
in_valid  in  1  count is sampled only on cycles where this is high
clr_err  in  1  clears err_sticky
phase  out  clog2(WIDTH)  binary index of the set bit of the last good sample
locked  out  1  high while state is LOCKED
rev_tick  out  1  one-cycle pulse on wrap from bit WIDTH-1 to bit 0 while locked
rev_cnt  out  REV_W  revolutions since reset, wraps mod 2^REV_W
err  out  1  one-cycle pulse on a bad sample while locked
err_sticky  out  1  set by err, held until clr_err or reset

Behaviour:
- Reset: state=SEARCH; prev, good_cnt, phase, rev_cnt = 0; locked, rev_tick, err, err_sticky = 0. Reset overrides all other inputs.
- All outputs are registered. Latency is 1 clk from the sampled edge to the output.
- in_valid=0: state, prev and counters hold. rev_tick and err are 0. No error is raised.
- Good step: sample is one-hot and sample == {prev[WIDTH-2:0], prev[WIDTH-1]} (rotate left).
- SEARCH:
  - valid one-hot sample -> ACQUIRE, prev=sample, good_cnt=0.
  - any other sample -> stay in SEARCH.
- ACQUIRE:
  - good step -> good_cnt+1, prev=sample. When good_cnt reaches LOCK_N -> LOCKED.
  - one-hot sample that is not a good step -> stay in ACQUIRE, good_cnt=0, prev=sample.
  - non-one-hot sample (including all-zero) -> SEARCH.
  - No err is raised in SEARCH or ACQUIRE.
- LOCKED:
  - good step -> phase=index(sample), prev=sample.
  - if additionally prev[WIDTH-1]=1 and sample[0]=1 -> rev_tick=1 and rev_cnt+1.
  - bad sample -> err=1, err_sticky=1, locked=0, state=SEARCH. phase and rev_cnt hold.
- In ACQUIRE, phase updates on every one-hot sample. locked stays 0 until LOCKED is reached.
- LOCK_N=1: a single good step after the first one-hot sample locks.
- clr_err and error in the same cycle: the error wins and err_sticky stays 1.
- rev_cnt at all-ones wraps to 0 and rev_tick still pulses.

Optional Feature:
RING_ERR_CNT_EN
- Defined: adds output err_cnt [7:0], reset to 0. It increments on every err pulse and saturates at 255. clr_err also clears it; a simultaneous error leaves it at 1.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package ring_pkg holds:
  - state enum: SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - function rotl1 (rotate left by one).
  - localparam for the phase width, clog2(WIDTH).
- Sub-module onehot_enc (combinational, param WIDTH): inputs code; outputs is_onehot and idx. Instantiated once on count.

Test Plan:
1. WIDTH=4, LOCK_N=3. Reset, then in_valid=1 with 0001,0010,0100,1000 -> locked=1 one cycle after the 1000 sample, phase=3, err=0.
2. From test 1, next sample 0001 -> rev_tick=1 for one cycle, rev_cnt=1, phase=0. Run 255 more revolutions -> rev_cnt wraps to 0.
3. While locked, sample 0011 -> err=1 for one cycle, err_sticky=1, locked=0. Then 0010,0100,1000,0001 -> relock. With RING_ERR_CNT_EN, err_cnt=1.
4. While locked, hold in_valid=0 for 5 cycles with count=0000 -> all outputs hold, no err. Resume with the correct next code -> stays locked.
5. In SEARCH, feed 0000 and 0101 -> state stays SEARCH, err=0. Skip-step 0001 then 0100 in ACQUIRE -> good_cnt reset, no err.
6. Assert clr_err in the same cycle as a locked-state error -> err_sticky=1. Assert reset mid-lock -> next edge all outputs 0, state SEARCH.
